// File: rtl/fft32_ctrl.sv
// Address/strobe sequencer for an in-place radix-2 DIT 32-point FFT (5 stages x 16 butterflies).
// Reads issue one butterfly per cycle; writes replay the read stream LAT cycles later.
module fft32_ctrl #(
   parameter int LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [2:0] stage,
   output logic       rd_en,
   output logic [4:0] rd_addr_a,
   output logic [4:0] rd_addr_b,
   output logic [3:0] tw_idx,
   output logic       wr_en,
   output logic [4:0] wr_addr_a,
   output logic [4:0] wr_addr_b
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t     state;
   logic [3:0] k;
   logic [2:0] cnt;

   // Butterfly k of stage s: {upper addr, lower addr, twiddle index}
   function automatic logic [13:0] bfly_addr(input logic [2:0] s, input logic [3:0] kk);
      logic [4:0] half;
      logic [4:0] pos;
      logic [4:0] a;
      logic [4:0] b;
      logic [3:0] tw;
      half = 5'd1 << s;
      pos  = {1'b0, kk} & (half - 5'd1);
      a    = (({1'b0, kk} >> s) << (s + 3'd1)) | pos;
      b    = a + half;
      tw   = pos[3:0] << (3'd4 - s);
      return {a, b, tw};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         cnt       <= '0;
         stage     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  k     <= '0;
                  stage <= '0;
                  busy  <= 1'b1;
                  rd_en <= 1'b1;
                  {rd_addr_a, rd_addr_b, tw_idx} <= bfly_addr(3'd0, 4'd0);
               end
            end
            RUN: begin
               if (k == 4'd15) begin
                  state <= DRAIN;
                  cnt   <= '0;
                  rd_en <= 1'b0;
               end else begin
                  k <= k + 4'd1;
                  {rd_addr_a, rd_addr_b, tw_idx} <= bfly_addr(stage, k + 4'd1);
               end
            end
            DRAIN: begin
               // Wait out the write pipeline so the next stage never reads stale data
               if (cnt == 3'(LAT - 1)) begin
                  if (stage == 3'd4) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     stage <= stage + 3'd1;
                     k     <= '0;
                     rd_en <= 1'b1;
                     {rd_addr_a, rd_addr_b, tw_idx} <= bfly_addr(stage + 3'd1, 4'd0);
                  end
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
               stage <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic       pipe_en [LAT];
   logic [4:0] pipe_a  [LAT];
   logic [4:0] pipe_b  [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_en[0] <= 1'b0;
         pipe_a[0]  <= '0;
         pipe_b[0]  <= '0;
      end else begin
         pipe_en[0] <= rd_en;
         pipe_a[0]  <= rd_addr_a;
         pipe_b[0]  <= rd_addr_b;
      end
   end

   generate
      for (genvar gi = 1; gi < LAT; gi++) begin : g_pipe
         always_ff @(posedge clk) begin
            if (rst) begin
               pipe_en[gi] <= 1'b0;
               pipe_a[gi]  <= '0;
               pipe_b[gi]  <= '0;
            end else begin
               pipe_en[gi] <= pipe_en[gi-1];
               pipe_a[gi]  <= pipe_a[gi-1];
               pipe_b[gi]  <= pipe_b[gi-1];
            end
         end
      end
   endgenerate

   assign wr_en     = pipe_en[LAT-1];
   assign wr_addr_a = pipe_a[LAT-1];
   assign wr_addr_b = pipe_b[LAT-1];

endmodule

// File: tb/tb_fft32_ctrl.sv
// Checks LAT=1/2/7 builds of fft32_ctrl side by side against a cycle-index model of the schedule.
module tb_fft32_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic start;

   always #5 clk = ~clk;

   logic [2:0] busy_v, done_v, rd_en_v, wr_en_v;
   logic [2:0] stage_v     [3];
   logic [4:0] rd_addr_a_v [3];
   logic [4:0] rd_addr_b_v [3];
   logic [3:0] tw_idx_v    [3];
   logic [4:0] wr_addr_a_v [3];
   logic [4:0] wr_addr_b_v [3];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : 7;
         fft32_ctrl #(.LAT(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .busy      (busy_v[gi]),
            .done      (done_v[gi]),
            .stage     (stage_v[gi]),
            .rd_en     (rd_en_v[gi]),
            .rd_addr_a (rd_addr_a_v[gi]),
            .rd_addr_b (rd_addr_b_v[gi]),
            .tw_idx    (tw_idx_v[gi]),
            .wr_en     (wr_en_v[gi]),
            .wr_addr_a (wr_addr_a_v[gi]),
            .wr_addr_b (wr_addr_b_v[gi])
         );
      end
   endgenerate

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   // Model state: t = cycle index since the start edge (1 = first busy cycle), -1 when idle
   int  lats [3] = '{1, 2, 7};
   int  t_m  [3];
   bit  clean[3];
   bit  h_en [3][8];
   int  h_a  [3][8];
   int  h_b  [3][8];
   int  cyc;
   int  done_at[3];
   bit  directed;

   function automatic void exp_rd(input int t, input int l, output bit en,
                                  output int a, output int b, output int tw);
      int p, s, off, half, pos, grp;
      en = 0; a = 0; b = 0; tw = 0;
      p = 16 + l;
      if (t < 1) return;
      s   = (t - 1) / p;
      off = (t - 1) % p;
      if (s > 4 || off >= 16) return;
      half = 2 ** s;
      pos  = off % half;
      grp  = off / half;
      en   = 1;
      a    = grp * 2 * half + pos;
      b    = a + half;
      tw   = pos * (16 / half);
   endfunction

   task automatic model_update(input bit st, input bit r);
      bit en; int a, b, tw, l, last;
      for (int i = 0; i < 3; i++) begin
         l = lats[i];
         last = 5 * (16 + l) + 1;
         exp_rd(t_m[i], l, en, a, b, tw);
         for (int j = 7; j > 0; j--) begin
            h_en[i][j] = h_en[i][j-1];
            h_a[i][j]  = h_a[i][j-1];
            h_b[i][j]  = h_b[i][j-1];
         end
         h_en[i][0] = en; h_a[i][0] = a; h_b[i][0] = b;
         if (r) begin
            t_m[i] = -1;
            clean[i] = 1;
            for (int j = 0; j < 8; j++) begin
               h_en[i][j] = 0; h_a[i][j] = 0; h_b[i][j] = 0;
            end
         end else if (t_m[i] >= 1) begin
            t_m[i] = (t_m[i] == last) ? -1 : t_m[i] + 1;
         end else if (st) begin
            t_m[i] = 1;
            clean[i] = 0;
         end
      end
   endtask

   // Hand-derived address points for the LAT=2 build: {t, a, b, tw}
   int dir_t [4] = '{6, 42, 64, 88};
   int dir_a [4] = '{10, 9, 17, 15};
   int dir_b [4] = '{11, 13, 25, 31};
   int dir_tw[4] = '{0, 4, 2, 15};

   task automatic compare_all();
      bit en; int a, b, tw, l, p, t, stg;
      string nm;
      for (int i = 0; i < 3; i++) begin
         l = lats[i]; p = 16 + l; t = t_m[i];
         nm = $sformatf("L%0d", l);
         exp_rd(t, l, en, a, b, tw);
         stg = (t < 1) ? 0 : (t == 5 * p + 1) ? 4 : (t - 1) / p;
         chk({nm, "_busy"},  int'(busy_v[i]),  int'(t >= 1));
         chk({nm, "_done"},  int'(done_v[i]),  int'(t == 5 * p + 1));
         chk({nm, "_stage"}, int'(stage_v[i]), stg);
         chk({nm, "_rd_en"}, int'(rd_en_v[i]), int'(en));
         if (en || clean[i]) begin
            chk({nm, "_rd_a"}, int'(rd_addr_a_v[i]), a);
            chk({nm, "_rd_b"}, int'(rd_addr_b_v[i]), b);
            chk({nm, "_tw"},   int'(tw_idx_v[i]),    tw);
         end
         chk({nm, "_wr_en"}, int'(wr_en_v[i]), int'(h_en[i][l-1]));
         if (h_en[i][l-1] || clean[i]) begin
            chk({nm, "_wr_a"}, int'(wr_addr_a_v[i]), h_a[i][l-1]);
            chk({nm, "_wr_b"}, int'(wr_addr_b_v[i]), h_b[i][l-1]);
         end
         if (done_v[i] === 1'b1 && done_at[i] == 0) done_at[i] = cyc;
      end
      if (directed) begin
         for (int j = 0; j < 4; j++) begin
            if (t_m[1] == dir_t[j]) begin
               chk($sformatf("dir%0d_a", j),  int'(rd_addr_a_v[1]), dir_a[j]);
               chk($sformatf("dir%0d_b", j),  int'(rd_addr_b_v[1]), dir_b[j]);
               chk($sformatf("dir%0d_tw", j), int'(tw_idx_v[1]),    dir_tw[j]);
            end
         end
      end
   endtask

   task automatic step(input bit st, input bit r);
      start = st;
      rst   = r;
      @(posedge clk);
      model_update(st, r);
      if (cyc > 0) cyc++;
      @(negedge clk);
      compare_all();
      $display("cyc=%0d start=%0b rst=%0b t=%0d/%0d/%0d busy=%b rd=%b wr=%b",
               cyc, st, r, t_m[0], t_m[1], t_m[2], busy_v, rd_en_v, wr_en_v);
   endtask

   int guard;

   initial begin
      start = 0; rst = 1;
      cyc = 0; directed = 1;
      for (int i = 0; i < 3; i++) begin
         t_m[i] = -1; clean[i] = 1; done_at[i] = 0;
         for (int j = 0; j < 8; j++) begin
            h_en[i][j] = 0; h_a[i][j] = 0; h_b[i][j] = 0;
         end
      end
      @(negedge clk);
      repeat (3) step(0, 1);
      repeat (2) step(0, 0);

      // First run; start re-pulsed mid-run must be ignored
      cyc = 0;
      step(1, 0);
      cyc = 1;
      guard = 0;
      while (t_m[2] != -1 && guard < 300) begin
         step(t_m[1] == 40, 0);
         guard++;
      end
      chk("run1_timeout", int'(guard < 300), 1);
      chk("done_cyc_L1", done_at[0], 86);
      chk("done_cyc_L2", done_at[1], 91);
      chk("done_cyc_L7", done_at[2], 116);
      cyc = 0;

      // Second run aborted by reset in stage 2, then a clean run
      step(1, 0);
      guard = 0;
      while (t_m[1] != 50 && guard < 300) begin
         step(0, 0);
         guard++;
      end
      chk("run2_timeout", int'(guard < 300), 1);
      step(0, 1);
      repeat (10) step(0, 0);
      step(1, 0);
      guard = 0;
      while (t_m[2] != -1 && guard < 300) begin
         step(0, 0);
         guard++;
      end
      chk("run3_timeout", int'(guard < 300), 1);
      directed = 0;

      // Random phase: sparse starts (often while busy), rare resets, occasional rst+start collisions
      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
      end
      step(1, 1);
      step(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
